pll_phase_ctrl: RTL and testbench

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

---
 rtl/pll_phase_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer for an EHXPLLL: latches a request, pulses PHASESTEP, then waits for lock.
// Latency: done asserts 1 cycle after accept for steps=0; otherwise SETUP_CYC + steps*(PULSE_CYC+GAP_CYC) + lock wait + 1.
// Backpressure: req_ready is high only while idle; a request is taken on req_valid & req_ready.
//
// Optional feature: define PLL_PHASE_LOADREG_EN to add a PHASELOADREG pulse (LOAD state) after the last step.
//
// Ports:
//   clk, rst_n                      single rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_sel, req_dir, req_steps     PLL output select, direction (1=lead), number of step pulses
//   pll_locked                      PLL lock, asynchronous (synchronized internally)
//   phasesel, phasedir              held from accept until the next accept
//   phasestep, phaseloadreg         idle-high, active-low pulses to the PLL
//   busy, done, err                 status: not idle, one-cycle completion, sticky lock timeout
module pll_phase_ctrl #(
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 4,
    parameter int GAP_CYC      = 4,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_steps,
    input  logic       pll_locked,
    output logic [1:0] phasesel,
    output logic       phasedir,
    output logic       phasestep,
    output logic       phaseloadreg,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CYC_MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CYC_MAX    = (CYC_MAX_SP > GAP_CYC) ? CYC_MAX_SP : GAP_CYC;
    localparam int CW         = $clog2(CYC_MAX + 1);
    localparam int SW         = $clog2(LOCK_STABLE + 1);
    localparam int TW         = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYC - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STEP,
        S_GAP,
        S_LOAD,
        S_LOCKWAIT,
        S_DONE
    } state_t;

    state_t        state_q;
    state_t        state_nxt;
    logic [CW-1:0] cyc_q;
    logic [7:0]    steps_q;
    logic [SW-1:0] stable_q;
    logic [TW-1:0] tmo_q;
    logic          load_gap_q;
    logic          load_gap_nxt;
    logic          tmo_exit;
    logic          lock_meta;
    logic          lock_s;
    logic          accept;
    logic          restart;

    // req_ready is a registered image of (state_q == S_IDLE), so it doubles as the idle test.
    assign accept  = req_valid & req_ready;
    // Phase counter restarts on every state change and on the low->high split inside LOAD.
    assign restart = (state_nxt != state_q) || (load_gap_nxt != load_gap_q);

    // Two-flop synchronizer for the asynchronous lock input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        load_gap_nxt = load_gap_q;
        tmo_exit     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_nxt    = (req_steps == 8'd0) ? S_DONE : S_SETUP;
                    load_gap_nxt = 1'b0;
                end
            end
            S_SETUP: begin
                if (cyc_q == SETUP_LAST) state_nxt = S_STEP;
            end
            S_STEP: begin
                if (cyc_q == PULSE_LAST) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (cyc_q == GAP_LAST) begin
                    // steps_q still holds the pre-decrement count here.
                    if (steps_q == 8'd1) begin
`ifdef PLL_PHASE_LOADREG_EN
                        state_nxt    = S_LOAD;
                        load_gap_nxt = 1'b0;
`else
                        state_nxt    = S_LOCKWAIT;
`endif
                    end else begin
                        state_nxt = S_STEP;
                    end
                end
            end
            S_LOAD: begin
                // First half drives PHASELOADREG low, second half is the high gap.
                if (!load_gap_q) begin
                    if (cyc_q == PULSE_LAST) load_gap_nxt = 1'b1;
                end else if (cyc_q == GAP_LAST) begin
                    state_nxt = S_LOCKWAIT;
                end
            end
            S_LOCKWAIT: begin
                // Stable lock is checked first so it wins a tie with the timeout.
                if (lock_s && (stable_q == STABLE_LAST)) begin
                    state_nxt = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    state_nxt = S_DONE;
                    tmo_exit  = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            load_gap_q <= 1'b0;
            cyc_q      <= '0;
            steps_q    <= 8'd0;
            stable_q   <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_nxt;
            load_gap_q <= load_gap_nxt;

            if (restart) begin
                cyc_q <= '0;
            end else if ((state_q == S_SETUP) || (state_q == S_STEP) ||
                         (state_q == S_GAP) || (state_q == S_LOAD)) begin
                cyc_q <= cyc_q + 1'b1;
            end

            if (accept) begin
                steps_q <= req_steps;
            end else if ((state_q == S_GAP) && (state_nxt != S_GAP)) begin
                steps_q <= steps_q - 8'd1;
            end

            // Any low synchronized lock cycle restarts the stability run.
            if ((state_q == S_LOCKWAIT) && lock_s) begin
                stable_q <= stable_q + 1'b1;
            end else begin
                stable_q <= '0;
            end

            if (state_q == S_LOCKWAIT) begin
                tmo_q <= tmo_q + 1'b1;
            end else begin
                tmo_q <= '0;
            end
        end
    end

    // Outputs are registered from the next state so the PLL control pins never glitch;
    // the asynchronous reset still returns the pulse pins high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phasesel     <= 2'd0;
            phasedir     <= 1'b1;
            phasestep    <= 1'b1;
            phaseloadreg <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            req_ready    <= 1'b1;
        end else begin
            if (accept) begin
                phasesel <= req_sel;
                phasedir <= req_dir;
            end
            phasestep <= (state_nxt != S_STEP);
`ifdef PLL_PHASE_LOADREG_EN
            phaseloadreg <= !((state_nxt == S_LOAD) && !load_gap_nxt);
`else
            phaseloadreg <= 1'b1;
`endif
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
            req_ready <= (state_nxt == S_IDLE);
            if (accept) begin
                err <= 1'b0;
            end else if (tmo_exit) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: schedule-based model checked every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: requests are held until req_ready is seen.
module tb_pll_phase_ctrl;

    localparam int S   = 2;
    localparam int P   = 4;
    localparam int G   = 4;
    localparam int STB = 16;
    localparam int TMO = 100;
`ifdef PLL_PHASE_LOADREG_EN
    localparam int LR = 1;
`else
    localparam int LR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'd0;
    logic       req_dir = 1'b0;
    logic [7:0] req_steps = 8'd0;
    logic       pll_locked = 1'b0;
    logic       req_ready;
    logic [1:0] phasesel;
    logic       phasedir;
    logic       phasestep;
    logic       phaseloadreg;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    pll_phase_ctrl #(
        .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sel      (req_sel),
        .req_dir      (req_dir),
        .req_steps    (req_steps),
        .pll_locked   (pll_locked),
        .phasesel     (phasesel),
        .phasedir     (phasedir),
        .phasestep    (phasestep),
        .phaseloadreg (phaseloadreg),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // d counts cycles since the accept cycle; everything is derived from the schedule.
    bit         m_active = 1'b0;
    int         m_d = 0;
    int         m_done_at = -1;
    int         m_steps = 0;
    int         m_run = 0;
    logic [1:0] m_sel = 2'd0;
    logic       m_dir = 1'b1;
    logic       m_err = 1'b0;
    logic       m_s1 = 1'b0;
    logic       m_s2 = 1'b0;
    int         cyc = 0;

    function automatic int pulses_end(input int steps);
        return S + steps * (P + G);
    endfunction

    initial forever begin
        logic lk;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_active = 1'b0; m_d = 0; m_done_at = -1; m_run = 0;
            m_sel = 2'd0; m_dir = 1'b1; m_err = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            lk   = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_locked;
            if (!m_active) begin
                if (req_valid) begin
                    m_active  = 1'b1;
                    m_d       = 1;
                    m_steps   = int'(req_steps);
                    m_sel     = req_sel;
                    m_dir     = req_dir;
                    m_err     = 1'b0;
                    m_run     = 0;
                    m_done_at = (req_steps == 8'd0) ? 1 : -1;
                end
            end else if (m_d == m_done_at) begin
                m_active = 1'b0;
            end else begin
                int e;
                e = pulses_end(m_steps) + LR * (P + G);
                if (m_done_at < 0 && m_d > e) begin
                    m_run = lk ? m_run + 1 : 0;
                    if (m_run == STB) begin
                        m_done_at = m_d + 1;
                    end else if (m_d - e == TMO) begin
                        m_done_at = m_d + 1;
                        m_err     = 1'b1;
                    end
                end
                m_d++;
            end
        end
    end

    function automatic logic [9:0] expected();
        logic rdy, bsy, dn, st, ld;
        int   pe;
        rdy = 1'b1; bsy = 1'b0; dn = 1'b0; st = 1'b1; ld = 1'b1;
        if (m_active) begin
            rdy = 1'b0;
            bsy = 1'b1;
            dn  = (m_d == m_done_at);
            pe  = pulses_end(m_steps);
            if (m_steps > 0 && m_d > S && m_d <= pe && ((m_d - S - 1) % (P + G)) < P) st = 1'b0;
            if (LR == 1 && m_steps > 0 && m_d > pe && m_d <= pe + P) ld = 1'b0;
        end
        return {rdy, bsy, dn, st, ld, m_sel, m_dir, m_err};
    endfunction

    // ---------------- compare + monitor ----------------
    int   pulses = 0;
    int   busy_cnt = 0;
    int   done_cyc = 0;
    int   acc_cyc = 0;
    int   prev_acc_cyc = 0;
    int   acc_cnt = 0;
    logic prev_step = 1'b1;

    initial forever begin
        logic [9:0] exp_v;
        @(negedge clk);
        exp_v = rst_n ? expected() : {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0};
        check("outputs{rdy,busy,done,step,load,sel,dir,err}",
              {22'd0, req_ready, busy, done, phasestep, phaseloadreg, phasesel, phasedir, err},
              {22'd0, exp_v});
        if (prev_step === 1'b1 && phasestep === 1'b0) pulses++;
        prev_step = phasestep;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cyc = cyc;
        if (req_valid && req_ready === 1'b1) begin
            prev_acc_cyc = acc_cyc;
            acc_cyc      = cyc;
            acc_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [1:0] sel, input logic dir, input logic [7:0] steps);
        bit ok;
        @(posedge clk); #1;
        req_sel = sel; req_dir = dir; req_steps = steps; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) check("req_ready_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) check(name, 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int mark, bmark, amark;
        bit ok;

        // Reset state
        pll_locked = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_phasesel", phasesel, 0);
        check("rst_phasedir", phasedir, 1);
        check("rst_phasestep", phasestep, 1);
        check("rst_phaseloadreg", phaseloadreg, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_req_ready", req_ready, 1);

        // Three steps, lock stable
        mark = pulses;
        send(2'd2, 1'b1, 8'd3);
        wait_done(300, "t3_done_timeout");
        check("t3_latency", done_cyc - acc_cyc, 43 + LR * 8);
        check("t3_pulses", pulses - mark, 3);
        check("t3_err", err, 0);
        check("t3_phasesel", phasesel, 2);
        check("t3_phasedir", phasedir, 1);

        // Zero steps
        repeat (2) @(posedge clk);
        mark = pulses; bmark = busy_cnt;
        send(2'd1, 1'b0, 8'd0);
        wait_done(50, "t0_done_timeout");
        repeat (3) @(posedge clk);
        check("t0_latency", done_cyc - acc_cyc, 1);
        check("t0_busy_cycles", busy_cnt - bmark, 1);
        check("t0_pulses", pulses - mark, 0);
        check("t0_phasesel", phasesel, 1);
        check("t0_phasedir", phasedir, 0);

        // Lock timeout with toggling lock
        pll_locked = 1'b0;
        send(2'd3, 1'b0, 8'd1);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin ok = 1'b1; break; end
            if ((i + 1) % 10 == 0) pll_locked = ~pll_locked;
        end
        if (!ok) check("tmo_done_timeout", 0, 1);
        @(posedge clk); #1;
        check("tmo_latency", done_cyc - acc_cyc, 111 + LR * 8);
        check("tmo_err_sticky", err, 1);
        pll_locked = 1'b1;
        repeat (5) @(posedge clk);
        send(2'd0, 1'b1, 8'd1);
        @(negedge clk);
        check("tmo_err_cleared", err, 0);
        wait_done(200, "tmo2_done_timeout");
        check("tmo2_latency", done_cyc - acc_cyc, 27 + LR * 8);
        check("tmo2_err", err, 0);

        // Reset during the second pulse of five
        mark = pulses;
        send(2'd0, 1'b0, 8'd5);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pulses - mark == 2 && phasestep === 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) check("rst_mid_pulse_not_reached", 0, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_phasestep", phasestep, 1);
        check("rstmid_busy", busy, 0);
        check("rstmid_phaseloadreg", phaseloadreg, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_req_ready", req_ready, 1);
        mark = pulses;
        repeat (60) @(negedge clk);
        check("rstmid_no_more_pulses", pulses - mark, 0);
        check("rstmid_idle", busy, 0);

        // Back-to-back requests with req_valid held high
        mark = pulses; amark = acc_cnt;
        @(posedge clk); #1;
        req_sel = 2'd1; req_dir = 1'b1; req_steps = 8'd1; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (acc_cnt - amark == 2) begin ok = 1'b1; break; end
        end
        if (!ok) check("b2b_second_accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done(200, "b2b_done_timeout");
        repeat (3) @(posedge clk);
        check("b2b_accept_spacing", acc_cyc - prev_acc_cyc, 28 + LR * 8);
        check("b2b_pulses", pulses - mark, 2);
        check("b2b_accepts", acc_cnt - amark, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
